// File: rtl/pf_pkg.sv
// rtl/pf_pkg.sv - shared types and helpers for protected_flag_bank
//
// Purpose: clear FSM state encoding, channel-index width helper and the
//          saturating counter ceiling used by protected_flag_bank.
// Ports:   none (package).

package pf_pkg;

  typedef enum logic {
    PF_IDLE  = 1'b0,
    PF_CLEAR = 1'b1
  } pf_state_t;

  // Width of a channel index; never below one bit so a single-channel
  // bank still has a legal first_ch_o port.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  // Largest value a cnt_width-bit counter may hold before it stops.
  function automatic logic [31:0] cnt_sat(input int cnt_width);
    return (cnt_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_width) - 32'd1);
  endfunction

endpackage

// File: rtl/pf_sync_edge.sv
// rtl/pf_sync_edge.sv - optional 2-flop synchronizer plus rising-edge detector
//
// Purpose: turns one channel's event request into a single-cycle event pulse.
// Ports:
//   clk     - clock
//   nreset  - asynchronous active-low reset
//   set_i   - event request (async when SYNC_EN=1, clk-synchronous otherwise)
//   ev      - one-cycle pulse on each rising edge of the (synchronized) request

module pf_sync_edge #(
  parameter int SYNC_EN = 1
) (
  input  logic clk,
  input  logic nreset,
  input  logic set_i,
  output logic ev
);

  logic w_s;
  logic w_filled;
  logic r_prev;
  logic r_armed;

  if (SYNC_EN != 0) begin : g_sync
    logic       r_meta;
    logic       r_sync;
    logic [1:0] r_fill;

    // r_fill tracks how many post-reset samples have reached r_sync, so the
    // reset value of the chain is never mistaken for a genuine low input.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
        r_fill <= 2'b00;
      end else begin
        r_meta <= set_i;
        r_sync <= r_meta;
        r_fill <= {r_fill[0], 1'b1};
      end
    end

    assign w_s      = r_sync;
    assign w_filled = r_fill[1];
  end else begin : g_direct
    assign w_s      = set_i;
    assign w_filled = 1'b1;
  end

  // A request that is already high when reset releases must fall and rise
  // again before it counts: the detector only arms after seeing a real low.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= w_s;
      r_armed <= r_armed | (w_filled & ~w_s);
    end
  end

  assign ev = w_s & ~r_prev & r_armed;

endmodule

// File: rtl/protected_flag_bank.sv
// rtl/protected_flag_bank.sv - multi-channel sticky protection flag bank
//
// Purpose: per channel, detects protection events, holds a sticky flag, keeps
//          the address of the first event, counts events (saturating) and
//          reports re-hits; globally records the first channel to fire and
//          offers a per-channel clear through a valid/ready handshake.
// Ports:
//   clk, nreset    - clock, asynchronous active-low reset
//   set_i          - per-channel event request (rising edge = event)
//   addr_i         - per-channel address, channel k at [k*BUS_WIDTH +: BUS_WIDTH]
//   clr_valid      - clear request
//   clr_mask       - channels to clear, sampled on handshake
//   clr_ready      - block can accept a clear
//   flag_o         - sticky per-channel flag
//   any_flag_o     - OR of flag_o
//   addr_o         - address captured at each channel's first event
//   cnt_o          - per-channel saturating event count
//   ovf_o          - event seen while the channel flag was already set
//   first_valid_o  - first_ch_o is meaningful
//   first_ch_o     - index of the first channel to fire

module protected_flag_bank
  import pf_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 8,
  parameter int SYNC_EN   = 1
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [NUM_CH-1:0]             set_i,
  input  logic [NUM_CH*BUS_WIDTH-1:0]   addr_i,
  input  logic                          clr_valid,
  input  logic [NUM_CH-1:0]             clr_mask,
  output logic                          clr_ready,
  output logic [NUM_CH-1:0]             flag_o,
  output logic                          any_flag_o,
  output logic [NUM_CH*BUS_WIDTH-1:0]   addr_o,
  output logic [NUM_CH*CNT_WIDTH-1:0]   cnt_o,
  output logic [NUM_CH-1:0]             ovf_o,
  output logic                          first_valid_o,
  output logic [ch_idx_w(NUM_CH)-1:0]   first_ch_o
);

  localparam int                   IDX_W   = ch_idx_w(NUM_CH);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(cnt_sat(CNT_WIDTH));

  pf_state_t         r_state;
  logic [NUM_CH-1:0] r_mask;
  logic              r_clr_ready;
  logic              r_first_valid;
  logic [IDX_W-1:0]  r_first_ch;

  logic [NUM_CH-1:0] w_ev;
  logic [NUM_CH-1:0] w_clr;
  logic              w_any_ev;
  logic [IDX_W-1:0]  w_first_idx;
  logic [NUM_CH-1:0] w_first_sel;
  logic              w_first_clr;

  // Channels being wiped at the end of this cycle.
  assign w_clr = (r_state == PF_CLEAR) ? r_mask : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic                 r_flag;
    logic                 r_ovf;
    logic [BUS_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0] r_cnt;

    pf_sync_edge #(
      .SYNC_EN (SYNC_EN)
    ) u_sync_edge (
      .clk    (clk),
      .nreset (nreset),
      .set_i  (set_i[k]),
      .ev     (w_ev[k])
    );

    // An event in the same cycle as a clear of this channel wins: the
    // channel restarts as if the clear had happened just before the event.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        r_flag <= 1'b0;
        r_ovf  <= 1'b0;
        r_addr <= '0;
        r_cnt  <= '0;
      end else if (w_ev[k]) begin
        r_flag <= 1'b1;
        if (w_clr[k]) begin
          r_addr <= addr_i[k*BUS_WIDTH +: BUS_WIDTH];
          r_cnt  <= CNT_WIDTH'(1);
          r_ovf  <= 1'b0;
        end else begin
          if (!r_flag) begin
            r_addr <= addr_i[k*BUS_WIDTH +: BUS_WIDTH];
          end else begin
            r_ovf <= 1'b1;
          end
          if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
      end else if (w_clr[k]) begin
        r_flag <= 1'b0;
        r_ovf  <= 1'b0;
        r_addr <= '0;
        r_cnt  <= '0;
      end
    end

    assign flag_o[k]                          = r_flag;
    assign ovf_o[k]                           = r_ovf;
    assign addr_o[k*BUS_WIDTH +: BUS_WIDTH]   = r_addr;
    assign cnt_o[k*CNT_WIDTH +: CNT_WIDTH]    = r_cnt;
  end

  // Lowest-index event wins; scanning downward leaves the lowest hit last.
  always_comb begin
    w_first_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_ev[k]) begin
        w_first_idx = IDX_W'(k);
      end
    end
  end

  assign w_any_ev    = |w_ev;
  assign w_first_sel = NUM_CH'(1) << r_first_ch;
  assign w_first_clr = r_first_valid & |(w_clr & w_first_sel);

  // Clearing the recorded first channel frees the slot, so an event landing
  // in that same cycle may claim it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
    end else if ((!r_first_valid || w_first_clr) && w_any_ev) begin
      r_first_valid <= 1'b1;
      r_first_ch    <= w_first_idx;
    end else if (w_first_clr) begin
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= PF_IDLE;
      r_mask      <= '0;
      r_clr_ready <= 1'b1;
    end else begin
      case (r_state)
        PF_IDLE: begin
          if (clr_valid) begin
            r_mask      <= clr_mask;
            r_state     <= PF_CLEAR;
            r_clr_ready <= 1'b0;
          end
        end
        PF_CLEAR: begin
          r_state     <= PF_IDLE;
          r_clr_ready <= 1'b1;
        end
        default: begin
          r_state     <= PF_IDLE;
          r_clr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign clr_ready     = r_clr_ready;
  assign any_flag_o    = |flag_o;
  assign first_valid_o = r_first_valid;
  assign first_ch_o    = r_first_ch;

endmodule

// File: tb/tb_protected_flag_bank.sv
// tb/tb_protected_flag_bank.sv - self-checking bench for protected_flag_bank
//
// Purpose: instance A (SYNC_EN=1, CNT_WIDTH=8) and instance B (SYNC_EN=0,
//          CNT_WIDTH=2) driven by directed vectors, checked every cycle
//          against a behavioural model plus literal expectations.

module tb_protected_flag_bank;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   set_a = '0, set_b = '0;
  logic [127:0] addr_a = '0, addr_b = '0;
  logic         cv_a = 1'b0, cv_b = 1'b0;
  logic [3:0]   cm_a = '0, cm_b = '0;

  logic         rdy_a, rdy_b, any_a, any_b, fv_a, fv_b;
  logic [3:0]   flag_a, flag_b, ovf_a, ovf_b;
  logic [127:0] ao_a, ao_b;
  logic [31:0]  cnt_a;
  logic [7:0]   cnt_b;
  logic [1:0]   fc_a, fc_b;

  int n_vec = 0;
  int n_err = 0;

  protected_flag_bank #(.BUS_WIDTH(32), .NUM_CH(4), .CNT_WIDTH(8), .SYNC_EN(1)) u_dut_a (
    .clk(clk), .nreset(nreset), .set_i(set_a), .addr_i(addr_a),
    .clr_valid(cv_a), .clr_mask(cm_a), .clr_ready(rdy_a),
    .flag_o(flag_a), .any_flag_o(any_a), .addr_o(ao_a), .cnt_o(cnt_a),
    .ovf_o(ovf_a), .first_valid_o(fv_a), .first_ch_o(fc_a)
  );

  protected_flag_bank #(.BUS_WIDTH(32), .NUM_CH(4), .CNT_WIDTH(2), .SYNC_EN(0)) u_dut_b (
    .clk(clk), .nreset(nreset), .set_i(set_b), .addr_i(addr_b),
    .clr_valid(cv_b), .clr_mask(cm_b), .clr_ready(rdy_b),
    .flag_o(flag_b), .any_flag_o(any_b), .addr_o(ao_b), .cnt_o(cnt_b),
    .ovf_o(ovf_b), .first_valid_o(fv_b), .first_ch_o(fc_b)
  );

  // Behavioural model: per instance, a history of sampled requests since
  // reset, and the per-channel state the rules describe.
  int          m_edges [2];
  logic [3:0]  m_hist  [2][4];
  logic [3:0]  m_flag  [2];
  logic [3:0]  m_ovf   [2];
  logic [31:0] m_addr  [2][4];
  int          m_cnt   [2][4];
  logic        m_fv    [2];
  int          m_fc    [2];
  logic        m_ready [2];
  logic [3:0]  m_mask  [2];

  task automatic model_reset(input int i);
    m_edges[i] = 0;
    for (int j = 0; j < 4; j++) begin
      m_hist[i][j] = '0;
      m_addr[i][j] = '0;
      m_cnt[i][j]  = 0;
    end
    m_flag[i]  = '0;
    m_ovf[i]   = '0;
    m_fv[i]    = 1'b0;
    m_fc[i]    = 0;
    m_ready[i] = 1'b1;
    m_mask[i]  = '0;
  endtask

  task automatic model_step(input int i, input logic [3:0] set, input logic [127:0] addr,
                            input logic cv, input logic [3:0] cm);
    int         lat;
    int         cmax;
    logic [3:0] ev;
    lat  = (i == 0) ? 2 : 0;
    cmax = (i == 0) ? 255 : 3;
    m_edges[i] = m_edges[i] + 1;
    for (int j = 3; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
    m_hist[i][0] = set;
    // A rise counts only if both samples forming it were taken after reset.
    ev = '0;
    if (m_edges[i] - lat - 1 >= 1) ev = m_hist[i][lat] & ~m_hist[i][lat+1];
    if (!m_ready[i]) begin
      for (int k = 0; k < 4; k++) begin
        if (m_mask[i][k]) begin
          m_flag[i][k] = 1'b0;
          m_ovf[i][k]  = 1'b0;
          m_addr[i][k] = '0;
          m_cnt[i][k]  = 0;
        end
      end
      if (m_fv[i] && m_mask[i][m_fc[i]]) begin
        m_fv[i] = 1'b0;
        m_fc[i] = 0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (ev[k]) begin
        if (!m_flag[i][k]) m_addr[i][k] = addr[k*32 +: 32];
        else               m_ovf[i][k]  = 1'b1;
        m_flag[i][k] = 1'b1;
        if (m_cnt[i][k] < cmax) m_cnt[i][k] = m_cnt[i][k] + 1;
      end
    end
    if (!m_fv[i] && ev != 4'b0) begin
      for (int k = 3; k >= 0; k--) if (ev[k]) m_fc[i] = k;
      m_fv[i] = 1'b1;
    end
    if (!m_ready[i]) begin
      m_ready[i] = 1'b1;
    end else if (cv) begin
      m_mask[i]  = cm;
      m_ready[i] = 1'b0;
    end
  endtask

  function automatic logic [127:0] exp_addr(input int i);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = m_addr[i][k];
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt(input int i, input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r = r | (32'(m_cnt[i][k]) << (k * w));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string p, input int i, input logic [3:0] fl, input logic an,
                          input logic [127:0] ad, input logic [31:0] cn, input logic [3:0] ov,
                          input logic fv, input logic [1:0] fc, input logic rd);
    chk({p, ".flag"},  128'(fl), 128'(m_flag[i]));
    chk({p, ".any"},   128'(an), 128'(|m_flag[i]));
    chk({p, ".addr"},  ad, exp_addr(i));
    chk({p, ".cnt"},   128'(cn), 128'(exp_cnt(i, (i == 0) ? 8 : 2)));
    chk({p, ".ovf"},   128'(ov), 128'(m_ovf[i]));
    chk({p, ".fv"},    128'(fv), 128'(m_fv[i]));
    chk({p, ".fc"},    128'(fc), 128'(m_fc[i]));
    chk({p, ".ready"}, 128'(rd), 128'(m_ready[i]));
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) begin
        model_reset(0);
        model_reset(1);
      end else begin
        model_step(0, set_a, addr_a, cv_a, cm_a);
        model_step(1, set_b, addr_b, cv_b, cm_b);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    forever begin
      @(negedge clk);
      #1;
      cmp_inst("a", 0, flag_a, any_a, ao_a, cnt_a, ovf_a, fv_a, fc_a, rdy_a);
      cmp_inst("b", 1, flag_b, any_b, ao_b, {24'b0, cnt_b}, ovf_b, fv_b, fc_b, rdy_b);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(4);
    chk("rst.flag_a",  128'(flag_a), 128'(0));
    chk("rst.ready_a", 128'(rdy_a),  128'(1));
    chk("rst.cnt_a",   128'(cnt_a),  128'(0));
    chk("rst.fv_b",    128'(fv_b),   128'(0));
    nreset = 1'b1;
    cyc(4);

    // First event on A channel 2 through the synchronizer.
    addr_a[95:64] = 32'h1000_00A0;
    set_a[2] = 1'b1;
    cyc(2);
    chk("t1.flag_early", 128'(flag_a[2]), 128'(0));
    cyc(1);
    chk("t1.flag",  128'(flag_a[2]),    128'(1));
    chk("t1.addr",  128'(ao_a[95:64]),  128'(32'h1000_00A0));
    chk("t1.cnt",   128'(cnt_a[23:16]), 128'(1));
    chk("t1.fc",    128'(fc_a),         128'(2));
    chk("t1.fv",    128'(fv_a),         128'(1));
    set_a[2] = 1'b0;
    cyc(3);

    // Re-hit on channel 2 keeps the first address.
    addr_a[95:64] = 32'h2000_0000;
    set_a[2] = 1'b1;
    cyc(3);
    chk("t2.addr", 128'(ao_a[95:64]),  128'(32'h1000_00A0));
    chk("t2.cnt",  128'(cnt_a[23:16]), 128'(2));
    chk("t2.ovf",  128'(ovf_a[2]),     128'(1));
    chk("t2.fc",   128'(fc_a),         128'(2));
    set_a[2] = 1'b0;
    cyc(3);

    // Simultaneous events on B channels 3 and 1.
    set_b = 4'b1010;
    cyc(1);
    chk("t3.flag", 128'(flag_b), 128'(4'b1010));
    chk("t3.fc",   128'(fc_b),   128'(1));
    chk("t3.fv",   128'(fv_b),   128'(1));
    set_b = 4'b0000;
    cyc(1);

    // Five events on B channel 0 with a 2-bit counter.
    for (int p = 0; p < 5; p++) begin
      set_b[0] = 1'b1;
      cyc(1);
      set_b[0] = 1'b0;
      cyc(1);
    end
    chk("t4.cnt0", 128'(cnt_b[1:0]), 128'(3));
    chk("t4.cnt1", 128'(cnt_b[3:2]), 128'(1));
    chk("t4.ovf0", 128'(ovf_b[0]),   128'(1));
    chk("t4.flag", 128'(flag_b),     128'(4'b1011));

    // Empty-mask clear still costs one cycle of clr_ready low.
    cv_b = 1'b1;
    cm_b = 4'b0000;
    cyc(1);
    cv_b = 1'b0;
    chk("c0.ready_low", 128'(rdy_b), 128'(0));
    cyc(1);
    chk("c0.ready",     128'(rdy_b),  128'(1));
    chk("c0.flag",      128'(flag_b), 128'(4'b1011));

    // Clearing the first channel drops first_valid.
    cv_b = 1'b1;
    cm_b = 4'b0010;
    cyc(1);
    cv_b = 1'b0;
    cyc(1);
    chk("c1.flag", 128'(flag_b),     128'(4'b1001));
    chk("c1.fv",   128'(fv_b),       128'(0));
    chk("c1.fc",   128'(fc_b),       128'(0));
    chk("c1.cnt1", 128'(cnt_b[3:2]), 128'(0));

    // Clear of A channel 2 colliding with a fresh channel 2 event.
    addr_a[31:0] = 32'h0000_0C00;
    set_a[0] = 1'b1;
    cyc(3);
    chk("t5.pre_flag0", 128'(flag_a[0]), 128'(1));
    set_a[0] = 1'b0;
    cyc(3);
    addr_a[95:64] = 32'h3000_0004;
    set_a[2] = 1'b1;
    cyc(1);
    cv_a = 1'b1;
    cm_a = 4'b0100;
    cyc(1);
    cv_a = 1'b0;
    chk("t5.ready_low", 128'(rdy_a), 128'(0));
    cyc(1);
    chk("t5.ready", 128'(rdy_a),        128'(1));
    chk("t5.flag2", 128'(flag_a[2]),    128'(1));
    chk("t5.cnt2",  128'(cnt_a[23:16]), 128'(1));
    chk("t5.ovf2",  128'(ovf_a[2]),     128'(0));
    chk("t5.addr2", 128'(ao_a[95:64]),  128'(32'h3000_0004));
    chk("t5.fc",    128'(fc_a),         128'(2));
    chk("t5.flag0", 128'(flag_a[0]),    128'(1));
    chk("t5.cnt0",  128'(cnt_a[7:0]),   128'(1));
    set_a[2] = 1'b0;
    cyc(3);

    // Reset in the middle of a CLEAR with channel 0 held high.
    set_a[0] = 1'b1;
    cyc(3);
    cv_a = 1'b1;
    cm_a = 4'b0001;
    cyc(1);
    cv_a = 1'b0;
    chk("t6.in_clear", 128'(rdy_a), 128'(0));
    nreset = 1'b0;
    #1;
    chk("t6.flag",  128'(flag_a), 128'(0));
    chk("t6.ready", 128'(rdy_a),  128'(1));
    chk("t6.cnt",   128'(cnt_a),  128'(0));
    chk("t6.addr",  ao_a,         128'(0));
    chk("t6.fv",    128'(fv_a),   128'(0));
    chk("t6.ovf",   128'(ovf_a),  128'(0));
    cyc(2);
    nreset = 1'b1;
    cyc(6);
    chk("t6.held_no_event", 128'(flag_a[0]), 128'(0));
    set_a[0] = 1'b0;
    cyc(2);
    set_a[0] = 1'b1;
    cyc(3);
    chk("t6.retoggle_flag", 128'(flag_a[0]),  128'(1));
    chk("t6.retoggle_cnt",  128'(cnt_a[7:0]), 128'(1));
    chk("t6.retoggle_fc",   128'(fc_a),       128'(0));
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
